mem_stage_ctrl: RTL and testbench
=================================

MEM_STAGE_CTRL -- requirements
Module: mem_stage_ctrl

Interface
REQ-001 SHALL have parameter IMG_WIDTH, default 256, pixels per row for pixel-address computation.
REQ-002 SHALL have parameter TIMEOUT, default 15, maximum wait cycles for an ack (used only under MEM_TIMEOUT_EN).
REQ-003 SHALL have port clk  input  1  sole clock; all state updates on the rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous and active-low.
REQ-005 SHALL have port in_valid  input  1  execute stage presents an instruction.
REQ-006 SHALL have ports in_pcSrc, in_regWrite, in_memWrite, in_memPixWrite  input  1 each  execute-to-memory control signals.
REQ-007 SHALL have port in_memToReg  input  2  write-back select: 00 ALU, 01 data memory, 10 pixel memory, 11 trig.
REQ-008 SHALL have ports in_aluResult, in_trigResult, in_Ax, in_Ay, in_WD  input  32 each  execute results, pixel coordinates and store data.
REQ-009 SHALL have port in_Rd  input  4  destination register.
REQ-010 SHALL have port stall  output  1  upstream must hold its outputs while high.
REQ-011 SHALL have ports dm_req, dm_we  output  1 each; dm_addr, dm_wdata  output  32 each; dm_ack  input  1; dm_rdata  input  32. This is the data-memory port.
REQ-012 SHALL have ports pm_req, pm_we  output  1 each; pm_addr  output  32; pm_wdata  output  8; pm_ack  input  1; pm_rdata  input  8. This is the pixel-memory port.
REQ-013 SHALL have ports wb_valid, wb_regWrite, wb_pcSrc  output  1 each; wb_memToReg  output  2; wb_dataMemRead, wb_pixMemRead, wb_aluResult, wb_trigResult  output  32 each; wb_Rd  output  4. This is the memory-to-writeback register.
REQ-014 SHALL have port err  output  1  sticky access-timeout flag.

Function
REQ-015 SHALL accept an instruction on a rising edge where in_valid=1 and stall=0, latching all in_* signals.
REQ-016 An instruction SHALL need a data access if in_memWrite=1 or in_memToReg=01, and a pixel access if in_memPixWrite=1 or in_memToReg=10.
REQ-017 FSM states SHALL be IDLE, DM_ACC, PM_ACC and WB. stall SHALL be 1 in every state except IDLE.
REQ-018 IDLE transitions: accepted instruction with a data access -> DM_ACC; pixel access only -> PM_ACC; no access -> WB.
REQ-019 DM_ACC: dm_req=1 and dm_we=latched memWrite; dm_addr=aluResult; dm_wdata=WD. On dm_ack, dm_rdata SHALL be captured, and the FSM SHALL go to PM_ACC if a pixel access is pending, else to WB.
REQ-020 PM_ACC: pm_req=1 and pm_we=latched memPixWrite; pm_addr=(Ay*IMG_WIDTH+Ax) truncated to 32 bits; pm_wdata=WD[7:0]. On pm_ack, pm_rdata SHALL be captured zero-extended to 32 bits, then the FSM SHALL go to WB.
REQ-021 Request signals SHALL be registered, and req SHALL remain stable until the ack cycle. req SHALL deassert the cycle after ack. Acks outside the matching ACC state SHALL be ignored.
REQ-022 WB: wb_valid=1 for exactly one cycle with the latched control, results and captured read data, then the FSM SHALL go to IDLE. A new instruction SHALL NOT be accepted in that same cycle.
REQ-023 Latency: 2 cycles from acceptance to wb_valid with no access. With accesses, 2 cycles plus the wait cycles before each ack.
REQ-024 Outside WB, wb_valid SHALL be 0, and the wb_* data SHALL hold their last values.
REQ-025 A write-only access SHALL leave the corresponding wb_*MemRead unchanged from its prior value.

Reset
REQ-026 When rst_n=0, the FSM SHALL go to IDLE, and all outputs including err SHALL be 0 immediately, without waiting for clk.
REQ-027 Reset asserted during DM_ACC or PM_ACC SHALL drop req at once and discard the instruction, with no wb_valid.
REQ-028 The first acceptance SHALL be possible on the first rising edge after rst_n deasserts.

Configuration
REQ-029 With macro MEM_TIMEOUT_EN defined, a wait counter SHALL count cycles in each ACC state. If the count reaches TIMEOUT without an ack, req SHALL drop, err SHALL set (sticky until reset), read data SHALL be captured as 0, and the FSM SHALL proceed as if acked.
REQ-030 Without MEM_TIMEOUT_EN, no counter SHALL exist, ACC states SHALL wait indefinitely, and err SHALL be constant 0.

Verification
REQ-031 ALU op: in_memToReg=00, aluResult=0x1234 accepted at cycle 0 -> wb_valid=1 at cycle 2, wb_aluResult=0x1234, stall=1 during cycle 1 only.
REQ-032 Data load: memToReg=01, aluResult=0x40, dm_ack 3 cycles after dm_req with dm_rdata=0xDEADBEEF -> dm_addr=0x40, dm_we=0, wb_dataMemRead=0xDEADBEEF, wb_valid one cycle after the ack cycle.
REQ-033 Pixel store: memPixWrite=1, Ax=5, Ay=2, WD=0x1AB, IMG_WIDTH=256 -> pm_addr=517, pm_wdata=0xAB, pm_we=1, dm_req never asserted.
REQ-034 Combined: memWrite=1 and memPixWrite=1 -> data access completes before pm_req rises, followed by a single wb_valid.
REQ-035 Reset mid-access: rst_n=0 while dm_req=1 -> dm_req=0, stall=0 and wb_valid=0 immediately; a subsequent ALU op completes normally.
REQ-036 MEM_TIMEOUT_EN, TIMEOUT=15, no pm_ack -> pm_req drops after 15 cycles, err=1, wb_pixMemRead=0, wb_valid pulses; err stays 1 until reset.

Source files
------------

// File: rtl/mem_stage_ctrl.sv
// mem_stage_ctrl -- memory-stage controller between execute and write-back.
// Latches one instruction from execute, performs its data-memory and/or
// pixel-memory access over a req/ack handshake, then presents the result in
// the memory-to-writeback register for one cycle. Upstream is stalled for the
// whole time an instruction is in flight.
// Optional feature: define MEM_TIMEOUT_EN to bound each access to TIMEOUT
// cycles. An expired wait returns 0 and sets the sticky err flag.
module mem_stage_ctrl #(
   parameter int unsigned IMG_WIDTH = 256,
   parameter int unsigned TIMEOUT   = 15
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        in_valid,
   input  logic        in_pcSrc,
   input  logic        in_regWrite,
   input  logic        in_memWrite,
   input  logic        in_memPixWrite,
   input  logic [1:0]  in_memToReg,
   input  logic [31:0] in_aluResult,
   input  logic [31:0] in_trigResult,
   input  logic [31:0] in_Ax,
   input  logic [31:0] in_Ay,
   input  logic [31:0] in_WD,
   input  logic [3:0]  in_Rd,
   output logic        stall,
   output logic        dm_req,
   output logic        dm_we,
   output logic [31:0] dm_addr,
   output logic [31:0] dm_wdata,
   input  logic        dm_ack,
   input  logic [31:0] dm_rdata,
   output logic        pm_req,
   output logic        pm_we,
   output logic [31:0] pm_addr,
   output logic [7:0]  pm_wdata,
   input  logic        pm_ack,
   input  logic [7:0]  pm_rdata,
   output logic        wb_valid,
   output logic        wb_regWrite,
   output logic        wb_pcSrc,
   output logic [1:0]  wb_memToReg,
   output logic [31:0] wb_dataMemRead,
   output logic [31:0] wb_pixMemRead,
   output logic [31:0] wb_aluResult,
   output logic [31:0] wb_trigResult,
   output logic [3:0]  wb_Rd,
   output logic        err
);

   typedef enum logic [1:0] {IDLE, DM_ACC, PM_ACC, WB} state_t;

   state_t      state, state_nxt;
   logic        accept, need_dm_in, need_pm_in;
   logic        need_dm, need_pm, pix_write;
   logic        reg_write, pc_src;
   logic [1:0]  mem_to_reg;
   logic [31:0] alu_result, trig_result;
   logic [3:0]  rd;
   logic [31:0] dm_data, dm_cap, dm_val, pix_addr;
   logic [7:0]  pm_cap;
   logic        timed_out, dm_done, pm_done, commit;

   assign accept     = in_valid && (state == IDLE);
   assign need_dm_in = in_memWrite || (in_memToReg == 2'b01);
   assign need_pm_in = in_memPixWrite || (in_memToReg == 2'b10);
   assign stall      = (state != IDLE);
   assign pix_addr   = in_Ay * 32'(IMG_WIDTH) + in_Ax;

   // An access ends on its ack, or on an expired wait (which reads as 0).
   assign dm_done = (state == DM_ACC) && (dm_ack || timed_out);
   assign pm_done = (state == PM_ACC) && (pm_ack || timed_out);
   assign dm_cap  = dm_ack ? dm_rdata : '0;
   assign pm_cap  = pm_ack ? pm_rdata : '0;
   // Data read used at commit: live when the data access is the last one,
   // otherwise the value staged before the pixel access.
   assign dm_val  = dm_done ? dm_cap : dm_data;

   // The result is committed at the end of the cycle that finishes the last
   // piece of work: the final ack for memory ops, the WB cycle for pure ALU ops.
   assign commit = (dm_done && !need_pm) || pm_done ||
                   ((state == WB) && !need_dm && !need_pm);

`ifdef MEM_TIMEOUT_EN
   localparam int unsigned CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

   logic [CNT_W-1:0] wait_cnt;
   logic             in_acc, cur_ack;

   assign in_acc    = (state == DM_ACC) || (state == PM_ACC);
   assign cur_ack   = (state == DM_ACC) ? dm_ack : pm_ack;
   assign timed_out = in_acc && !cur_ack && (wait_cnt == CNT_LAST);

   // Wait counter restarts on every entry into an access state.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) wait_cnt <= '0;
      else        wait_cnt <= (in_acc && (state_nxt == state)) ? wait_cnt + 1'b1 : '0;
   end

   // Sticky timeout flag, cleared only by reset.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)         err <= 1'b0;
      else if (timed_out) err <= 1'b1;
   end
`else
   assign timed_out = 1'b0;
   assign err       = 1'b0;
`endif

   // State register.
   // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nxt;
   end

   // Next-state selection; data access always precedes the pixel access.
   // NOTE: the default assignment first keeps this block free of inferred latches.
   always_comb begin
      state_nxt = state;
      unique case (state)
         IDLE:    if (accept) state_nxt = need_dm_in ? DM_ACC : (need_pm_in ? PM_ACC : WB);
         DM_ACC:  if (dm_done) state_nxt = need_pm ? PM_ACC : WB;
         PM_ACC:  if (pm_done) state_nxt = WB;
         WB:      state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // Latch the accepted instruction; stage the data read for a following pixel access.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         need_dm     <= 1'b0;
         need_pm     <= 1'b0;
         pix_write   <= 1'b0;
         reg_write   <= 1'b0;
         pc_src      <= 1'b0;
         mem_to_reg  <= 2'b00;
         alu_result  <= '0;
         trig_result <= '0;
         rd          <= '0;
         dm_data     <= '0;
      end else begin
         if (accept) begin
            need_dm     <= need_dm_in;
            need_pm     <= need_pm_in;
            pix_write   <= in_memPixWrite;
            reg_write   <= in_regWrite;
            pc_src      <= in_pcSrc;
            mem_to_reg  <= in_memToReg;
            alu_result  <= in_aluResult;
            trig_result <= in_trigResult;
            rd          <= in_Rd;
         end
         if (dm_done) dm_data <= dm_cap;
      end
   end

   // Registered request ports: raised on entry to an access, dropped after its ack.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         dm_req   <= 1'b0;
         dm_we    <= 1'b0;
         dm_addr  <= '0;
         dm_wdata <= '0;
         pm_req   <= 1'b0;
         pm_we    <= 1'b0;
         pm_addr  <= '0;
         pm_wdata <= '0;
      end else if (accept) begin
         dm_req   <= need_dm_in;
         dm_we    <= in_memWrite;
         dm_addr  <= in_aluResult;
         dm_wdata <= in_WD;
         pm_req   <= need_pm_in && !need_dm_in;
         pm_we    <= need_pm_in && !need_dm_in && in_memPixWrite;
         pm_addr  <= pix_addr;
         pm_wdata <= in_WD[7:0];
      end else begin
         if (dm_done) begin
            dm_req <= 1'b0;
            dm_we  <= 1'b0;
            pm_req <= need_pm;
            pm_we  <= need_pm && pix_write;
         end
         if (pm_done) begin
            pm_req <= 1'b0;
            pm_we  <= 1'b0;
         end
      end
   end

   // Memory-to-writeback register: one-cycle valid pulse, data held otherwise.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wb_valid       <= 1'b0;
         wb_regWrite    <= 1'b0;
         wb_pcSrc       <= 1'b0;
         wb_memToReg    <= 2'b00;
         wb_dataMemRead <= '0;
         wb_pixMemRead  <= '0;
         wb_aluResult   <= '0;
         wb_trigResult  <= '0;
         wb_Rd          <= '0;
      end else begin
         wb_valid <= commit;
         if (commit) begin
            wb_regWrite   <= reg_write;
            wb_pcSrc      <= pc_src;
            wb_memToReg   <= mem_to_reg;
            wb_aluResult  <= alu_result;
            wb_trigResult <= trig_result;
            wb_Rd         <= rd;
            if (mem_to_reg == 2'b01) wb_dataMemRead <= dm_val;
            if (mem_to_reg == 2'b10) wb_pixMemRead  <= {24'h0, pm_cap};
         end
      end
   end

endmodule

// File: tb/tb_mem_stage_ctrl.sv
// tb_mem_stage_ctrl -- directed and randomized checks of mem_stage_ctrl
// against a transaction-level timing and data model.
// The timeout scenario is included only when MEM_TIMEOUT_EN is defined.
`timescale 1ns/1ps
module tb_mem_stage_ctrl;

   localparam int unsigned IMG_WIDTH = 256;
   localparam int unsigned TIMEOUT   = 15;

   logic        clk, rst_n;
   logic        in_valid, in_pcSrc, in_regWrite, in_memWrite, in_memPixWrite;
   logic [1:0]  in_memToReg;
   logic [31:0] in_aluResult, in_trigResult, in_Ax, in_Ay, in_WD;
   logic [3:0]  in_Rd;
   logic        stall;
   logic        dm_req, dm_we, dm_ack;
   logic [31:0] dm_addr, dm_wdata, dm_rdata;
   logic        pm_req, pm_we, pm_ack;
   logic [31:0] pm_addr;
   logic [7:0]  pm_wdata, pm_rdata;
   logic        wb_valid, wb_regWrite, wb_pcSrc;
   logic [1:0]  wb_memToReg;
   logic [31:0] wb_dataMemRead, wb_pixMemRead, wb_aluResult, wb_trigResult;
   logic [3:0]  wb_Rd;
   logic        err;

   mem_stage_ctrl #(.IMG_WIDTH(IMG_WIDTH), .TIMEOUT(TIMEOUT)) dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid),
      .in_pcSrc(in_pcSrc), .in_regWrite(in_regWrite), .in_memWrite(in_memWrite),
      .in_memPixWrite(in_memPixWrite), .in_memToReg(in_memToReg),
      .in_aluResult(in_aluResult), .in_trigResult(in_trigResult),
      .in_Ax(in_Ax), .in_Ay(in_Ay), .in_WD(in_WD), .in_Rd(in_Rd),
      .stall(stall),
      .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
      .dm_ack(dm_ack), .dm_rdata(dm_rdata),
      .pm_req(pm_req), .pm_we(pm_we), .pm_addr(pm_addr), .pm_wdata(pm_wdata),
      .pm_ack(pm_ack), .pm_rdata(pm_rdata),
      .wb_valid(wb_valid), .wb_regWrite(wb_regWrite), .wb_pcSrc(wb_pcSrc),
      .wb_memToReg(wb_memToReg), .wb_dataMemRead(wb_dataMemRead),
      .wb_pixMemRead(wb_pixMemRead), .wb_aluResult(wb_aluResult),
      .wb_trigResult(wb_trigResult), .wb_Rd(wb_Rd), .err(err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic        pc_src, reg_write, mem_write, pix_write;
      logic [1:0]  mem_to_reg;
      logic [31:0] alu, trig, ax, ay, wd;
      logic [3:0]  rd;
   } instr_t;

   int unsigned n_checks = 0;
   int unsigned n_pass   = 0;

   // Model of the architecturally visible write-back state.
   logic [31:0] exp_dm_read  = '0;
   logic [31:0] exp_pix_read = '0;
   logic [31:0] exp_alu_hold = '0;
   logic        exp_err      = 1'b0;
   bit          pending_wb   = 1'b0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
   endtask

   function automatic instr_t mk(input logic [1:0] mtr, input logic mw, input logic mpw,
                                 input logic [31:0] alu, input logic [31:0] ax,
                                 input logic [31:0] ay, input logic [31:0] wd);
      instr_t i;
      i.pc_src = 1'b0; i.reg_write = (mtr != 2'b00) || !mw; i.mem_write = mw;
      i.pix_write = mpw; i.mem_to_reg = mtr; i.alu = alu; i.trig = 32'h7716_0001;
      i.ax = ax; i.ay = ay; i.wd = wd; i.rd = 4'h3;
      return i;
   endfunction

   function automatic instr_t rand_instr();
      instr_t i;
      i.pc_src = 1'($urandom); i.reg_write = 1'($urandom);
      i.mem_write = 1'($urandom); i.pix_write = 1'($urandom);
      i.mem_to_reg = 2'($urandom);
      i.alu = $urandom; i.trig = $urandom; i.ax = $urandom; i.ay = $urandom;
      i.wd = $urandom; i.rd = 4'($urandom);
      return i;
   endfunction

   task automatic drive(input instr_t i);
      in_pcSrc = i.pc_src; in_regWrite = i.reg_write; in_memWrite = i.mem_write;
      in_memPixWrite = i.pix_write; in_memToReg = i.mem_to_reg;
      in_aluResult = i.alu; in_trigResult = i.trig; in_Ax = i.ax; in_Ay = i.ay;
      in_WD = i.wd; in_Rd = i.rd;
   endtask

   // Runs one instruction. dd/pd: request cycles seen without ack before the
   // ack cycle. Each access occupies (wait+1) cycles, a pure ALU op one WB
   // cycle; the write-back pulse follows in the next cycle.
   task automatic run_instr(input instr_t i, input int dd, input int pd, input bit pm_silent);
      bit          nd, np;
      int          dm_e, pm_s, pm_e, lat, stall_last;
      logic [31:0] exp_pa;
      nd = i.mem_write || (i.mem_to_reg == 2'b01);
      np = i.pix_write || (i.mem_to_reg == 2'b10);
      dm_e = 1 + dd;
      pm_s = nd ? dm_e + 1 : 1;
      pm_e = pm_s + pd;
      lat = 1 + (nd ? dd + 1 : 0) + (np ? pd + 1 : 0) + ((nd || np) ? 0 : 1);
      stall_last = (nd || np) ? lat : lat - 1;
      exp_pa = i.ay * IMG_WIDTH + i.ax;

      drive(i);
      in_valid = 1'b1;
      if (pending_wb) begin
         @(negedge clk);
         check("idle_wb_valid", 32'(wb_valid), 32'(0));
         check("idle_stall", 32'(stall), 32'(0));
      end
      @(posedge clk);
      for (int c = 1; c <= lat; c++) begin
         @(negedge clk);
         if (c == 1) begin
            in_valid = 1'b0;
            drive(rand_instr());
            check("wb_hold_alu", wb_aluResult, exp_alu_hold);
         end
         check("stall", 32'(stall), 32'(c <= stall_last));
         check("wb_valid", 32'(wb_valid), 32'(c == lat));
         check("dm_req", 32'(dm_req), 32'(nd && c <= dm_e));
         check("pm_req", 32'(pm_req), 32'(np && c >= pm_s && c <= pm_e));
         if (nd && c == 1) begin
            check("dm_addr", dm_addr, i.alu);
            check("dm_we", 32'(dm_we), 32'(i.mem_write));
            check("dm_wdata", dm_wdata, i.wd);
         end
         if (np && c == pm_s) begin
            check("pm_addr", pm_addr, exp_pa);
            check("pm_we", 32'(pm_we), 32'(i.pix_write));
            check("pm_wdata", 32'(pm_wdata), {24'h0, i.wd[7:0]});
         end
         dm_rdata = $urandom;
         pm_rdata = 8'($urandom);
         if (nd && c <= dm_e) dm_ack = (c == dm_e);
         else                 dm_ack = ($urandom_range(0, 3) == 0);
         if (np && c >= pm_s && c <= pm_e) pm_ack = (c == pm_e) && !pm_silent;
         else                              pm_ack = ($urandom_range(0, 3) == 0);
         if (nd && c == dm_e && i.mem_to_reg == 2'b01) exp_dm_read = dm_rdata;
         if (np && c == pm_e && i.mem_to_reg == 2'b10)
            exp_pix_read = pm_silent ? 32'h0 : {24'h0, pm_rdata};
         if (np && c == pm_e && pm_silent) exp_err = 1'b1;
         if (c == lat) begin
            check("wb_regWrite", 32'(wb_regWrite), 32'(i.reg_write));
            check("wb_pcSrc", 32'(wb_pcSrc), 32'(i.pc_src));
            check("wb_memToReg", 32'(wb_memToReg), 32'(i.mem_to_reg));
            check("wb_aluResult", wb_aluResult, i.alu);
            check("wb_trigResult", wb_trigResult, i.trig);
            check("wb_Rd", 32'(wb_Rd), 32'(i.rd));
            check("wb_dataMemRead", wb_dataMemRead, exp_dm_read);
            check("wb_pixMemRead", wb_pixMemRead, exp_pix_read);
            check("err", 32'(err), 32'(exp_err));
         end
      end
      exp_alu_hold = i.alu;
      pending_wb = nd || np;
   endtask

   initial begin
      instr_t ld;
      rst_n = 1'b0; in_valid = 1'b0; dm_ack = 1'b0; pm_ack = 1'b0;
      dm_rdata = '0; pm_rdata = '0;
      drive(rand_instr());
      #13;
      check("rst_stall", 32'(stall), 32'(0));
      check("rst_dm_req", 32'(dm_req), 32'(0));
      check("rst_pm_req", 32'(pm_req), 32'(0));
      check("rst_wb_valid", 32'(wb_valid), 32'(0));
      check("rst_err", 32'(err), 32'(0));
      check("rst_dm_addr", dm_addr, 32'h0);
      check("rst_pm_addr", pm_addr, 32'h0);
      check("rst_wb_alu", wb_aluResult, 32'h0);
      @(negedge clk);
      rst_n = 1'b1;

      // Directed: ALU op, data load, pixel store, combined and mixed accesses.
      run_instr(mk(2'b00, 1'b0, 1'b0, 32'h1234, 32'h0, 32'h0, 32'h0), 0, 0, 1'b0);
      run_instr(mk(2'b01, 1'b0, 1'b0, 32'h40, 32'h0, 32'h0, 32'h0), 3, 0, 1'b0);
      run_instr(mk(2'b00, 1'b0, 1'b1, 32'h99, 32'd5, 32'd2, 32'h1AB), 0, 2, 1'b0);
      check("pixel_store_addr_517", pm_addr, 32'd517);
      run_instr(mk(2'b00, 1'b1, 1'b1, 32'h80, 32'd7, 32'd9, 32'hCAFE_F00D), 1, 2, 1'b0);
      run_instr(mk(2'b01, 1'b0, 1'b1, 32'h84, 32'd1, 32'd1, 32'h55), 0, 0, 1'b0);
      run_instr(mk(2'b10, 1'b0, 1'b0, 32'h88, 32'd300, 32'd40, 32'h0), 0, 0, 1'b0);
      run_instr(mk(2'b00, 1'b1, 1'b0, 32'h8C, 32'd0, 32'd0, 32'h1357), 0, 0, 1'b0);
      run_instr(mk(2'b11, 1'b0, 1'b0, 32'h90, 32'd0, 32'd0, 32'h0), 0, 0, 1'b0);

      // Randomized instructions and ack delays.
      for (int n = 0; n < 40; n++)
         run_instr(rand_instr(), $urandom_range(0, 5), $urandom_range(0, 5), 1'b0);

      // Reset in the middle of a data access.
      ld = mk(2'b01, 1'b0, 1'b0, 32'h100, 32'h0, 32'h0, 32'h0);
      dm_ack = 1'b0; pm_ack = 1'b0;
      drive(ld);
      in_valid = 1'b1;
      if (pending_wb) @(negedge clk);
      @(posedge clk);
      for (int c = 0; c < 3; c++) begin
         @(negedge clk);
         in_valid = 1'b0;
         dm_ack = 1'b0;
      end
      check("pre_rst_dm_req", 32'(dm_req), 32'(1));
      #2 rst_n = 1'b0;
      #1;
      check("mid_rst_dm_req", 32'(dm_req), 32'(0));
      check("mid_rst_stall", 32'(stall), 32'(0));
      check("mid_rst_wb_valid", 32'(wb_valid), 32'(0));
      check("mid_rst_err", 32'(err), 32'(0));
      exp_dm_read = '0; exp_pix_read = '0; exp_alu_hold = '0; exp_err = 1'b0;
      pending_wb = 1'b0;
      repeat (2) @(posedge clk);
      #1 check("rst_no_wb_valid", 32'(wb_valid), 32'(0));
      @(negedge clk);
      rst_n = 1'b1;
      run_instr(mk(2'b00, 1'b0, 1'b0, 32'h4321, 32'h0, 32'h0, 32'h0), 0, 0, 1'b0);

`ifdef MEM_TIMEOUT_EN
      // Pixel load that is never acked: request held for TIMEOUT cycles.
      run_instr(mk(2'b10, 1'b0, 1'b0, 32'hA0, 32'd3, 32'd4, 32'h0), 0, TIMEOUT - 1, 1'b1);
      run_instr(mk(2'b00, 1'b0, 1'b0, 32'hA4, 32'h0, 32'h0, 32'h0), 0, 0, 1'b0);
      check("err_sticky", 32'(err), 32'(1));
`endif

      @(negedge clk);
      check("final_wb_valid_low", 32'(wb_valid), 32'(0));
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
